// File: rtl/led_framebuf_if.sv
// Command port of the LED frame buffer: one byte-wide read-modify-write
// operation per accepted transfer (valid/ready handshake).
interface led_framebuf_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [4:0] cmd_addr;
   logic [7:0] cmd_data;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_addr,
      output cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_addr,
      input  cmd_data,
      output cmd_ready
   );
endinterface

// File: rtl/led_framebuf.sv
// Double-buffered 32-byte frame store for the MAX7219 chain driver.
// Commands edit the back buffer; a commit copies it whole into the front
// buffer (data), so the driver never sees a half-drawn image. A clear engine
// blanks the back buffer one byte per cycle, and commits that arrive while it
// runs are held back until the last byte has been blanked.
module led_framebuf #(
   parameter logic [255:0] INIT_PATTERN = 256'h0,
   parameter logic [7:0]   CLEAR_BYTE   = 8'h00
) (
   input  logic          clk,
   input  logic          rst_n,
   led_framebuf_if.slave cmd,
   input  logic          commit,
   input  logic          clear,
   output logic          busy,
   output logic          commit_ack,
   output logic [255:0]  data
);

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   state_t       state_q, state_next;
   logic [4:0]   ptr_q, ptr_next;
   logic         pending_q, pending_next;
   logic [255:0] back_q, back_next;
   logic         load_front;
   logic         ack_q;
   logic         cmd_fire;
   logic [7:0]   cmd_lsb;
   logic [7:0]   clr_lsb;
   logic [7:0]   cmd_old;
   logic [7:0]   cmd_new;

   // Byte i lives at bits [255-8i -: 8], so its lsb sits at 248-8i.
   assign cmd_lsb  = 8'd248 - {cmd.cmd_addr, 3'b000};
   assign clr_lsb  = 8'd248 - {ptr_q, 3'b000};

   assign busy          = (state_q == ST_CLEAR);
   assign cmd.cmd_ready = !busy;
   assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;
   assign commit_ack    = ack_q;

   // Read-modify-write of the addressed back-buffer byte.
   always_comb begin
      cmd_old = back_q[cmd_lsb +: 8];
      cmd_new = cmd_old;
      case (cmd.cmd_op)
         2'b00:   cmd_new = cmd.cmd_data;
         2'b01:   cmd_new = cmd_old | cmd.cmd_data;
         2'b10:   cmd_new = cmd_old & ~cmd.cmd_data;
         default: cmd_new = cmd_old ^ cmd.cmd_data;
      endcase
   end

   // Next back buffer, clear sequencing and the decision to load the front.
   // A commit loads the next-state back buffer so a same-cycle command is
   // included; during a clear it is deferred to the final blanking cycle.
   always_comb begin
      state_next   = state_q;
      ptr_next     = ptr_q;
      pending_next = pending_q;
      back_next    = back_q;
      load_front   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               back_next[cmd_lsb +: 8] = cmd_new;
            end
            if (commit) begin
               load_front = 1'b1;
            end
            if (clear) begin
               state_next = ST_CLEAR;
               ptr_next   = 5'd0;
            end
         end
         ST_CLEAR: begin
            back_next[clr_lsb +: 8] = CLEAR_BYTE;
            ptr_next = ptr_q + 5'd1;
            if (commit) begin
               pending_next = 1'b1;
            end
            if (ptr_q == 5'd31) begin
               state_next   = ST_IDLE;
               load_front   = commit || pending_q;
               pending_next = 1'b0;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Control state: FSM state, clear pointer and deferred-commit flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 5'd0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_next;
         ptr_q     <= ptr_next;
         pending_q <= pending_next;
      end
   end

   // Frame storage: back buffer always follows, front only on a load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         back_q <= INIT_PATTERN;
         data   <= INIT_PATTERN;
         ack_q  <= 1'b0;
      end else begin
         back_q <= back_next;
         ack_q  <= load_front;
         if (load_front) begin
            data <= back_next;
         end
      end
   end

endmodule

// File: tb/tb_led_framebuf.sv
// Self-checking bench for led_framebuf: directed table, multi-cycle corner
// sequences and randomized traffic compared against a byte-array model.
module tb_led_framebuf;

   localparam logic [255:0] INIT_PATTERN = 256'h0;
   localparam logic [7:0]   CLEAR_BYTE   = 8'h00;
   localparam logic [255:0] ALL_ONES     = {256{1'b1}};
   localparam logic [255:0] ONLY_BYTE2   = 256'h55 << 232;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         commit = 1'b0;
   logic         clear = 1'b0;
   logic         busy;
   logic         commit_ack;
   logic [255:0] data;

   led_framebuf_if cmd_if();

   led_framebuf #(
      .INIT_PATTERN(INIT_PATTERN),
      .CLEAR_BYTE  (CLEAR_BYTE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd       (cmd_if),
      .commit    (commit),
      .clear     (clear),
      .busy      (busy),
      .commit_ack(commit_ack),
      .data      (data)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: plain byte arrays plus a count of clear cycles left.
   logic [7:0] m_back [32];
   logic [7:0] m_front [32];
   int         m_clr_left;
   bit         m_pend;
   bit         m_ack;

   typedef struct {
      bit         v;
      logic [1:0] op;
      logic [4:0] a;
      logic [7:0] d;
      bit         c;
      bit         clr;
      int         idx;
      logic [7:0] exp_byte;
      bit         exp_ack;
   } vec_t;

   vec_t vecs [11];

   function automatic logic [255:0] frontVec();
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < 32; i++) v[255 - 8*i -: 8] = m_front[i];
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 32; i++) begin
         m_back[i]  = INIT_PATTERN[255 - 8*i -: 8];
         m_front[i] = INIT_PATTERN[255 - 8*i -: 8];
      end
      m_clr_left = 0;
      m_pend     = 1'b0;
      m_ack      = 1'b0;
   endtask

   task automatic modelStep(input bit v, input logic [1:0] op, input logic [4:0] a,
                            input logic [7:0] d, input bit c, input bit clr);
      logic [7:0] nb [32];
      nb    = m_back;
      m_ack = 1'b0;
      if (v && m_clr_left == 0) begin
         case (op)
            2'b00:   nb[a] = d;
            2'b01:   nb[a] = m_back[a] | d;
            2'b10:   nb[a] = m_back[a] & ~d;
            default: nb[a] = m_back[a] ^ d;
         endcase
      end
      if (m_clr_left > 0) begin
         nb[32 - m_clr_left] = CLEAR_BYTE;
         if (c) m_pend = 1'b1;
         if (m_clr_left == 1) begin
            if (m_pend) begin
               m_front = nb;
               m_ack   = 1'b1;
            end
            m_pend = 1'b0;
         end
         m_clr_left--;
      end else begin
         if (c) begin
            m_front = nb;
            m_ack   = 1'b1;
         end
         if (clr) m_clr_left = 32;
      end
      m_back = nb;
   endtask

   // Drive one cycle of inputs, let the edge happen, advance the model.
   task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [4:0] a,
                                input logic [7:0] d, input bit c, input bit clr);
      cmd_if.cmd_valid = v;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_addr  = a;
      cmd_if.cmd_data  = d;
      commit           = c;
      clear            = clr;
      @(posedge clk);
      modelStep(v, op, a, d, c, clr);
      #1;
   endtask

   task automatic checkOutput();
      checkVal("busy", busy, m_clr_left > 0);
      checkVal("cmd_ready", cmd_if.cmd_ready, m_clr_left == 0);
      checkVal("commit_ack", commit_ack, m_ack);
      checkVal("data", data, frontVec());
   endtask

   initial begin
      int  busy_cycles;
      int  acks;
      int  held;
      bit  fell;
      bit  ones_ok;
      bit  ready_low_ok;
      bit  pre_busy;
      int  after;

      vecs[0]  = '{1, 2'b00, 5'd0,  8'hA5, 0, 0, 0,  8'h00, 0};
      vecs[1]  = '{0, 2'b00, 5'd0,  8'h00, 1, 0, 0,  8'hA5, 1};
      vecs[2]  = '{0, 2'b00, 5'd0,  8'h00, 0, 0, 0,  8'hA5, 0};
      vecs[3]  = '{1, 2'b00, 5'd31, 8'hF0, 0, 0, 31, 8'h00, 0};
      vecs[4]  = '{1, 2'b01, 5'd31, 8'h0F, 0, 0, 31, 8'h00, 0};
      vecs[5]  = '{1, 2'b10, 5'd31, 8'h3C, 0, 0, 31, 8'h00, 0};
      vecs[6]  = '{1, 2'b11, 5'd31, 8'hFF, 0, 0, 31, 8'h00, 0};
      vecs[7]  = '{0, 2'b00, 5'd0,  8'h00, 1, 0, 31, 8'h3C, 1};
      vecs[8]  = '{1, 2'b00, 5'd5,  8'h81, 1, 0, 5,  8'h81, 1};
      vecs[9]  = '{0, 2'b00, 5'd0,  8'h00, 0, 0, 5,  8'h81, 0};
      vecs[10] = '{0, 2'b00, 5'd0,  8'h00, 0, 0, 0,  8'hA5, 0};

      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 2'b00;
      cmd_if.cmd_addr  = 5'd0;
      cmd_if.cmd_data  = 8'h00;
      modelReset();

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      checkVal("reset data", data, INIT_PATTERN);
      checkVal("reset busy", busy, 1'b0);
      checkVal("reset cmd_ready", cmd_if.cmd_ready, 1'b1);
      checkVal("reset commit_ack", commit_ack, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int k = 0; k < 11; k++) begin
         applyStimulus(vecs[k].v, vecs[k].op, vecs[k].a, vecs[k].d, vecs[k].c, vecs[k].clr);
         checkOutput();
         checkVal($sformatf("vec%0d byte", k), data[255 - 8*vecs[k].idx -: 8], vecs[k].exp_byte);
         checkVal($sformatf("vec%0d ack", k), commit_ack, vecs[k].exp_ack);
         checkVal($sformatf("vec%0d busy", k), busy, 1'b0);
      end

      // Fill with ones, commit, clear, deferred commit three cycles later
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1, 2'b00, 5'(i), 8'hFF, 0, 0);
         checkOutput();
      end
      applyStimulus(0, 2'b00, 5'd0, 8'h00, 1, 0);
      checkOutput();
      checkVal("fill all ones", data, ALL_ONES);
      busy_cycles  = 0;
      acks         = 0;
      fell         = 1'b0;
      ones_ok      = 1'b1;
      ready_low_ok = 1'b1;
      after        = 0;
      for (int cyc = 0; cyc < 60 && after < 3; cyc++) begin
         applyStimulus(0, 2'b00, 5'd0, 8'h00, cyc == 3, cyc == 0);
         checkOutput();
         if (commit_ack) acks++;
         if (busy) begin
            busy_cycles++;
            if (data !== ALL_ONES) ones_ok = 1'b0;
            if (cmd_if.cmd_ready !== 1'b0) ready_low_ok = 1'b0;
         end else if (!fell) begin
            fell = 1'b1;
            checkVal("data at busy fall", data, 256'h0);
            checkVal("ack at busy fall", commit_ack, 1'b1);
         end else begin
            after++;
         end
      end
      checkVal("busy fell", fell, 1'b1);
      checkVal("busy cycle count", busy_cycles, 32);
      checkVal("deferred ack count", acks, 1);
      checkVal("front held during clear", ones_ok, 1'b1);
      checkVal("ready low during clear", ready_low_ok, 1'b1);

      // Command held valid through a clear
      applyStimulus(0, 2'b00, 5'd0, 8'h00, 0, 1);
      checkOutput();
      held = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         pre_busy = busy;
         applyStimulus(1, 2'b00, 5'd2, 8'h55, 0, 0);
         checkOutput();
         if (!pre_busy) break;
         held++;
      end
      checkVal("held cycles while busy", held, 32);
      applyStimulus(0, 2'b00, 5'd0, 8'h00, 1, 0);
      checkOutput();
      checkVal("held command image", data, ONLY_BYTE2);

      // Reset at clear cycle 10 with a commit pending
      applyStimulus(1, 2'b00, 5'd7, 8'h3E, 1, 0);
      checkOutput();
      applyStimulus(0, 2'b00, 5'd0, 8'h00, 0, 1);
      for (int cyc = 1; cyc < 10; cyc++) begin
         applyStimulus(0, 2'b00, 5'd0, 8'h00, cyc == 3, 0);
         checkOutput();
      end
      commit = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkVal("mid-clear reset busy", busy, 1'b0);
      checkVal("mid-clear reset ready", cmd_if.cmd_ready, 1'b1);
      checkVal("mid-clear reset data", data, INIT_PATTERN);
      checkVal("mid-clear reset ack", commit_ack, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         applyStimulus(0, 2'b00, 5'd0, 8'h00, 0, 0);
         checkOutput();
         if (commit_ack) acks++;
      end
      checkVal("no ack after reset", acks, 0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         applyStimulus($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                       5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
                       $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0);
         checkOutput();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
